// File: rtl/thread_pc_sequencer_pkg.sv
// Shared thread/PC definitions for the fetch front end, the downstream
// controller and the data-path wrappers.
package thread_pc_sequencer_pkg;

  localparam int THREAD_COUNT      = 8;
  localparam int THREAD_ADDR_WIDTH = $clog2(THREAD_COUNT);
  localparam int PC_WIDTH          = 10;

  typedef logic [THREAD_ADDR_WIDTH-1:0] thread_id_t;
  typedef logic [PC_WIDTH-1:0]          pc_t;

  localparam pc_t PC_START_DEFAULT = '0;

endpackage

// File: rtl/thread_counter.sv
// Free-running modulo-THREAD_COUNT thread phase counter; shared by every
// stage that needs to know which thread owns the current cycle.
module thread_counter
  import thread_pc_sequencer_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset,
  output logic [THREAD_ADDR_WIDTH-1:0] cnt
);

  // THREAD_COUNT is a power of two, so natural overflow gives the modulo.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/thread_pc_sequencer.sv
// Round-robin PC stage: each cycle issues the selected thread's PC as the
// instruction-memory address and advances it, honouring downstream redirects.
module thread_pc_sequencer
  import thread_pc_sequencer_pkg::*;
#(
  parameter pc_t PC_START = PC_START_DEFAULT
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [THREAD_COUNT-1:0]      thread_run,
  input  logic                         redirect_valid,
  input  logic [THREAD_ADDR_WIDTH-1:0] redirect_thread,
  input  logic [PC_WIDTH-1:0]          redirect_pc,
  output logic [PC_WIDTH-1:0]          I_read_addr,
  output logic [THREAD_ADDR_WIDTH-1:0] I_thread,
  output logic                         I_valid
);

  thread_id_t cnt;
  pc_t        pc_q [THREAD_COUNT];
  pc_t        pc_d [THREAD_COUNT];

  thread_counter u_thread_counter (
    .clock (clock),
    .reset (reset),
    .cnt   (cnt)
  );

  // A redirect overrides the same-cycle advance of its target thread.
  always_comb begin
    for (int t = 0; t < THREAD_COUNT; t++) begin
      pc_d[t] = pc_q[t];
      if (redirect_valid && (redirect_thread == thread_id_t'(t))) begin
        pc_d[t] = redirect_pc;
      end else if ((cnt == thread_id_t'(t)) && thread_run[t]) begin
        pc_d[t] = pc_q[t] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= '{default: PC_START};
    end else begin
      pc_q <= pc_d;
    end
  end

  // Stopped threads still present their PC; I_valid marks the bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      I_read_addr <= '0;
      I_thread    <= '0;
      I_valid     <= 1'b0;
    end else begin
      I_read_addr <= pc_q[cnt];
      I_thread    <= cnt;
      I_valid     <= thread_run[cnt];
    end
  end

endmodule
